// File: rtl/add_defs.sv
// Shared definitions for the pipelined adder: operation mode encoding and chunk sizing.
package add_defs;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } add_mode_e;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit chunking_ok(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CW-bit ripple adder made of fulladder cells; one per pipeline stage.
module add_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          c_in,
    output logic [CW-1:0] s,
    output logic          c_out
);
    logic [CW:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < CW; i++) begin : g_bit
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .c_in (carry[i]),
            .s    (s[i]),
            .c_out(carry[i+1])
        );
    end

    assign c_out = carry[CW];
endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell used to build the ripple chunks.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit add/subtract, one CW-bit chunk per stage, valid/ready with full backpressure.
// Optional zero/neg/ovf result flags are enabled by defining ADD_PIPE_FLAGS_EN.
module add_pipe
    import add_defs::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef ADD_PIPE_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);
    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!chunking_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("add_pipe: WIDTH must be >= 2, STAGES in 1..WIDTH, and WIDTH divisible by STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    // The whole pipe moves as one shift register; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = (sub == MODE_SUB) ? ~b : b;
    assign cin0     = (sub == MODE_SUB) ? 1'b1 : c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRC_W = WIDTH - k * CW;
        localparam int LOW_W = (k + 1) * CW;

        logic [SRC_W-1:0] src_a;
        logic [SRC_W-1:0] src_b;
        logic             src_c;
        logic             src_v;
        logic [CW-1:0]    chunk_s;
        logic             chunk_c;
        logic [LOW_W-1:0] sum_d;
        logic [LOW_W-1:0] sum_q;
        logic             carry_q;
        logic             valid_q;

        if (k == 0) begin : g_head
            assign src_a = a;
            assign src_b = b_eff;
            assign src_c = cin0;
            assign src_v = in_valid;
            assign sum_d = chunk_s;
        end else begin : g_body
            assign src_a = g_stage[k-1].g_fwd.rem_a_q;
            assign src_b = g_stage[k-1].g_fwd.rem_b_q;
            assign src_c = g_stage[k-1].carry_q;
            assign src_v = g_stage[k-1].valid_q;
            assign sum_d = {chunk_s, g_stage[k-1].sum_q};
        end

        add_chunk #(.CW(CW)) u_chunk (
            .a    (src_a[CW-1:0]),
            .b    (src_b[CW-1:0]),
            .c_in (src_c),
            .s    (chunk_s),
            .c_out(chunk_c)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= src_v;
                carry_q <= chunk_c;
                sum_q   <= sum_d;
            end
        end

        // Operands are shifted down as they travel, so each stage always adds its low chunk.
        if (k < STAGES - 1) begin : g_fwd
            logic [SRC_W-CW-1:0] rem_a_q;
            logic [SRC_W-CW-1:0] rem_b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rem_a_q <= '0;
                    rem_b_q <= '0;
                end else if (adv) begin
                    rem_a_q <= src_a[SRC_W-1:CW];
                    rem_b_q <= src_b[SRC_W-1:CW];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign s         = g_stage[STAGES-1].sum_q;
    assign c_out     = g_stage[STAGES-1].carry_q;

`ifdef ADD_PIPE_FLAGS_EN
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic [WIDTH-1:0] last_sum;
    logic             sign_a;
    logic             sign_b;

    // Sign bits seen by the last stage are those of a and the possibly inverted b.
    assign last_sum = g_stage[STAGES-1].sum_d;
    assign sign_a   = g_stage[STAGES-1].src_a[CW-1];
    assign sign_b   = g_stage[STAGES-1].src_b[CW-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            zero_q <= (last_sum == '0);
            neg_q  <= last_sum[WIDTH-1];
            ovf_q  <= (sign_a == sign_b) && (last_sum[WIDTH-1] != sign_a);
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: directed vectors, backpressure, reset mid-flight, width/depth sweep.
module tb_add_pipe;
    localparam int W   = 32;
    localparam int S   = 4;
    localparam int NSW = 4;
    localparam int SW_W [NSW] = '{16, 16, 64, 64};
    localparam int SW_S [NSW] = '{1, 8, 1, 8};
    localparam int NRND = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
    logic [W-1:0] a, b, s;
`ifdef ADD_PIPE_FLAGS_EN
    logic zero, neg, ovf;
`endif

    add_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .c_out    (c_out)
`ifdef ADD_PIPE_FLAGS_EN
        ,
        .zero     (zero),
        .neg      (neg),
        .ovf      (ovf)
`endif
    );

    logic               sw_valid, sw_cin, sw_sub;
    logic [63:0]        sw_a, sw_b;
    logic [NSW-1:0]     sw_ir, sw_ov, sw_co;
    logic [NSW*64-1:0]  sw_s;

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        localparam int GW = SW_W[g];
        localparam int GS = SW_S[g];
        logic [GW-1:0] s_w;
`ifdef ADD_PIPE_FLAGS_EN
        logic z_w, n_w, o_w;
`endif
        add_pipe #(.WIDTH(GW), .STAGES(GS)) u_sw (
            .clk      (clk),
            .rst      (rst),
            .in_valid (sw_valid),
            .in_ready (sw_ir[g]),
            .a        (sw_a[GW-1:0]),
            .b        (sw_b[GW-1:0]),
            .c_in     (sw_cin),
            .sub      (sw_sub),
            .out_valid(sw_ov[g]),
            .out_ready(1'b1),
            .s        (s_w),
            .c_out    (sw_co[g])
`ifdef ADD_PIPE_FLAGS_EN
            ,
            .zero     (z_w),
            .neg      (n_w),
            .ovf      (o_w)
`endif
        );
        assign sw_s[g*64 +: 64] = 64'(s_w);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c_in;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        z;
        logic        n;
        logic        o;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        @(posedge clk); #1;
        a = v.a; b = v.b; c_in = v.c_in; sub = v.sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({name, " latency"}, 64'(lat), 64'(S));
        check({name, " s"}, 64'(s), 64'(v.s));
        check({name, " c_out"}, 64'(c_out), 64'(v.c));
`ifdef ADD_PIPE_FLAGS_EN
        check({name, " zero"}, 64'(zero), 64'(v.z));
        check({name, " neg"}, 64'(neg), 64'(v.n));
        check({name, " ovf"}, 64'(ovf), 64'(v.o));
`endif
    endtask

    function automatic logic [64:0] ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                                            input logic ci, input logic sb);
        logic [64:0] mask;
        logic [64:0] xx, yy;
        mask = (65'd1 << w) - 65'd1;
        xx   = {1'b0, x} & mask;
        yy   = (sb ? {1'b0, ~y} : {1'b0, y}) & mask;
        return xx + yy + (sb ? 65'd1 : {64'd0, ci});
    endfunction

    logic [64:0] exp_q [NSW][$];
    int          t_q   [NSW][$];
    int          tick;

    logic [31:0] held_s;
    logic        stalled;
    int          issued, got, stale;
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        tick = 0;

        #12;
        check("reset out_valid", 64'(out_valid), 64'd0);
        #10 rst = 1'b0;
        @(negedge clk);
        check("reset s", 64'(s), 64'd0);
        check("reset c_out", 64'(c_out), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset sweep out_valid", 64'(sw_ov), 64'd0);

        for (int i = 0; i < NVEC; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // backpressure: 8 back-to-back ops, out_ready pattern 1,0,0,1 repeating
        issued = 0; got = 0; stalled = 1'b0; held_s = '0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            @(posedge clk); #1;
            out_ready = pat[cyc % 4];
            if (issued < 8) begin
                in_valid = 1'b1; a = 32'(issued); b = 32'(issued); c_in = 1'b0; sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("bp in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (stalled) begin
                check("bp hold valid", 64'(out_valid), 64'd1);
                check("bp hold s", 64'(s), 64'(held_s));
            end
            if (in_valid && in_ready) issued++;
            if (out_valid && out_ready) begin
                check("bp order", 64'(s), 64'(2 * got));
                got++;
            end
            stalled = out_valid && !out_ready;
            held_s  = s;
        end
        check("bp result count", 64'(got), 64'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);

        // reset asserted mid-flight while the third op is being presented
        @(posedge clk); #1; in_valid = 1'b1; a = 32'd100; b = 32'd1; c_in = 1'b0; sub = 1'b0;
        @(posedge clk); #1; a = 32'd200;
        @(posedge clk); #1; a = 32'd300;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst async out_valid", 64'(out_valid), 64'd0);
        check("rst async s", 64'(s), 64'd0);
        check("rst async c_out", 64'(c_out), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0; in_valid = 1'b0;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst no stale results", 64'(stale), 64'd0);
        run_vec('{32'h0BAD_F00D, 32'h0000_0001, 1'b0, 1'b0, 32'h0BAD_F00E, 1'b0, 1'b0, 1'b0, 1'b0},
                "post-reset");

        // random sweep over WIDTH 16/64 x STAGES 1/8, continuous issue with out_ready held high
        for (int cyc = 0; cyc < NRND + 20; cyc++) begin
            @(posedge clk); #1;
            if (cyc < NRND) begin
                sw_valid = 1'b1;
                sw_a     = {$urandom(), $urandom()};
                sw_b     = {$urandom(), $urandom()};
                sw_cin   = 1'($urandom_range(0, 1));
                sw_sub   = 1'($urandom_range(0, 1));
            end else begin
                sw_valid = 1'b0;
            end
            @(negedge clk);
            tick++;
            for (int g = 0; g < NSW; g++) begin
                if (sw_ov[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("sweep%0d unexpected output", g), 64'd1, 64'd0);
                    end else begin
                        logic [64:0] r;
                        logic [63:0] m;
                        int          t0;
                        r  = exp_q[g].pop_front();
                        t0 = t_q[g].pop_front();
                        m  = 64'((65'd1 << SW_W[g]) - 65'd1);
                        check($sformatf("sweep%0d s", g), sw_s[g*64 +: 64], r[63:0] & m);
                        check($sformatf("sweep%0d c_out", g), 64'(sw_co[g]), 64'(r[SW_W[g]]));
                        check($sformatf("sweep%0d latency", g), 64'(tick - t0), 64'(SW_S[g]));
                    end
                end
                if (sw_valid && sw_ir[g]) begin
                    exp_q[g].push_back(ref_add(SW_W[g], sw_a, sw_b, sw_cin, sw_sub));
                    t_q[g].push_back(tick);
                end
            end
        end
        for (int g = 0; g < NSW; g++)
            check($sformatf("sweep%0d drained", g), 64'(exp_q[g].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined successor of the 32-bit combinational ripple adder.
- Splits a WIDTH-bit add or subtract into STAGES carry-chained chunks, one chunk per register stage.
- Uses valid/ready handshakes on input and output, and supports full backpressure.
- Sits between operand-select logic and the result mux in the ALU datapath; sustains one operation per cycle.

Parameters:
- WIDTH, 32: operand/result width in bits; must be ≥ 2 and divisible by STAGES.
- STAGES, 4: pipeline depth and chunk count; chunk width CW = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry in (add mode); ignored when sub=1
- sub  in  1  0: s=a+b+c_in; 1: s=a-b (a + ~b + 1)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum/difference
- c_out  out  1  carry out of MSB (for sub: 1 = no borrow)

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, out_valid = 0, s = 0, c_out = 0. Data registers are cleared too. Any in-flight operations are discarded.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Advance: adv = !out_valid || out_ready. All stages shift together when adv=1 and hold completely when adv=0.
- in_ready = adv (combinational from out_valid and out_ready; no path from in_valid).
- Stage 0 on transfer:
  - Capture a, b' = sub ? ~b : b, and cin0 = sub ? 1 : c_in.
  - Add chunk 0: a[CW-1:0] + b'[CW-1:0] + cin0.
  - Store the chunk-0 sum, its carry, and the remaining upper operand chunks.
- Stage k (1..STAGES-1): add chunk k using the carry registered by stage k-1. Lower sum bits pass through; higher operand chunks are carried forward.
- Stage valid bits: each bit loads its predecessor's valid on adv. Stage 0's valid loads (in_valid && in_ready) on adv, so bubbles propagate as invalid.
- Latency: exactly STAGES cycles from input transfer to out_valid=1 when out_ready is held 1.
- Throughput: 1 op/cycle with out_ready=1.
- s and c_out are registered and held stable while out_valid && !out_ready.
- STAGES=1: a single registered adder, latency 1.
- Arithmetic is modulo 2^WIDTH; wrap-around is reported only via c_out.
- Results leave in input order. There is no reordering and no drops under stall.
- Simultaneous input and output transfer in the same cycle is legal and required at full rate.
- Reset mid-operation clears all valids within the same cycle (async). No result is emitted for pre-reset inputs.

Optional Feature:
- Macro: ADD_PIPE_FLAGS_EN.
- Defined: adds output ports
  - zero (s == 0)
  - neg (s[WIDTH-1])
  - ovf (signed overflow: operand sign bits, post-invert of b, equal and differ from s[WIDTH-1])
- Flags are registered alongside s, follow the same valid/hold rules, and reset to 0.
- Undefined: flag ports and logic are absent. The rest of the behaviour is identical.

Decomposition:
- Shared package/header add_defs: the ADD/SUB mode encoding constants and the chunk-width computation (WIDTH/STAGES), plus a compile-time check of divisibility.
- Sub-module add_chunk: combinational CW-bit ripple adder built from the existing fulladder cells, with ports a, b, c_in, s, c_out. It is instantiated once per stage in a generate loop.

Test Plan:
- Basic add, WIDTH=32, STAGES=4, out_ready=1: a=0x0000_0001, b=0x0000_0001, c_in=0 -> after 4 cycles s=0x0000_0002, c_out=0.
- Carry across every chunk: a=0xFFFF_FFFF, b=0x0000_0000, c_in=1 -> s=0x0000_0000, c_out=1 (ovf=0, zero=1 with flags).
- Subtract:
  - a=5, b=7, sub=1 -> s=0xFFFF_FFFE, c_out=0 (neg=1).
  - a=0x8000_0000, b=1, sub=1 -> s=0x7FFF_FFFF, ovf=1.
- Backpressure: stream 8 back-to-back ops (a=i, b=i) with out_ready toggled 1,0,0,1,... -> outputs 0,2,4,...,14 in order; s stable during stalls; in_ready low exactly when out_valid && !out_ready.
- Reset mid-flight: issue 3 ops, assert rst for 1 cycle during cycle 2 -> out_valid stays 0 and no stale results appear; the next op after release returns the correct result with latency 4.
- Parameter sweep: STAGES=1 and STAGES=8 with WIDTH=16 and 64, 1000 random ops each vs a reference model -> all s and c_out match, latency = STAGES.
